// File: rtl/fft_pkg.sv
// Shared FFT stream definitions: frame geometry, complex sample layout and tdata packing.
package fft_pkg;

  localparam int N_BINS  = 8;
  localparam int IW      = $clog2(N_BINS);
  localparam int DW      = 16;
  localparam int TDATA_W = 2 * DW;
  localparam int RE_LSB  = 0;
  localparam int IM_LSB  = DW;
  localparam int PW      = 2 * DW;

  // First field lands in the upper half of tdata.
  typedef struct packed {
    logic signed [DW-1:0] im;
    logic signed [DW-1:0] re;
  } cplx_t;

endpackage

// File: rtl/fft_bin_power_avg_if.sv
// FFT beat input stream and averaged power spectrum output stream.
interface fft_bin_power_avg_if;
  import fft_pkg::*;

  logic [TDATA_W-1:0] s_tdata;
  logic [IW-1:0]      s_tuser;
  logic               s_tvalid;
  logic [PW-1:0]      m_tdata;
  logic [IW-1:0]      m_tuser;
  logic               m_tvalid;
  logic               m_tlast;
  logic               m_det;

  modport slave (
    input  s_tdata, s_tuser, s_tvalid,
    output m_tdata, m_tuser, m_tvalid, m_tlast, m_det
  );

  modport master (
    output s_tdata, s_tuser, s_tvalid,
    input  m_tdata, m_tuser, m_tvalid, m_tlast, m_det
  );
endinterface

// File: rtl/cplx_pow.sv
// Registered complex magnitude squared, re^2 + im^2, one cycle latency.
module cplx_pow
  import fft_pkg::*;
(
  input  logic          clk,
  input  cplx_t         x,
  output logic [PW-1:0] pow_p1
);

  logic signed [PW-1:0] re_sq;
  logic signed [PW-1:0] im_sq;

  // Each square is at most 2^30, so the unsigned sum fits in PW bits.
  always_comb begin
    re_sq = x.re * x.re;
    im_sq = x.im * x.im;
  end

  always_ff @(posedge clk) begin
    pow_p1 <= $unsigned(re_sq) + $unsigned(im_sq);
  end

endmodule

// File: rtl/fft_bin_power_avg.sv
// Per-bin FFT power averaged over 2^LOG2_AVG frames, with frame order checking and threshold detect.
module fft_bin_power_avg
  import fft_pkg::*;
#(
  parameter int LOG2_AVG = 4
) (
  input  logic                 clk,
  input  logic                 rstn,
  fft_bin_power_avg_if.slave   bus,
  input  logic [PW-1:0]        thresh,
  output logic                 seq_err,
  output logic [15:0]          err_cnt
);

  localparam int AW = PW + LOG2_AVG;
  localparam logic [LOG2_AVG-1:0] LAST_FRAME = '1;
  localparam logic [IW-1:0]       LAST_BIN   = IW'(N_BINS - 1);

  function automatic logic [PW-1:0] avg_of(input logic [AW-1:0] s);
    return PW'(s >> LOG2_AVG);
  endfunction

  function automatic logic [15:0] sat_inc(input logic [15:0] c);
    return (c == 16'hFFFF) ? c : c + 16'd1;
  endfunction

  logic [IW-1:0]       exp_bin, exp_nxt;
  logic                accept, brk;
  logic [IW-1:0]       bin_p1;
  logic                vld_p1, clr_p1;
  logic [PW-1:0]       pow_p1;
  logic [AW-1:0]       acc [N_BINS];
  logic [LOG2_AVG-1:0] frame_cnt, cur_fcnt;
  logic [AW-1:0]       cur_acc, sum_p1;
  logic [PW-1:0]       avg_p1;
  logic                final_frame;

  // Stage 0: bin order check
  always_comb begin
    accept  = 1'b0;
    brk     = 1'b0;
    exp_nxt = exp_bin;
    if (bus.s_tvalid) begin
      if (bus.s_tuser == exp_bin) begin
        accept  = 1'b1;
        exp_nxt = exp_bin + 1'b1;
      end else begin
        brk = 1'b1;
        // A stray bin 0 is taken as the start of a new frame.
        if (bus.s_tuser == '0) begin
          accept  = 1'b1;
          exp_nxt = IW'(1);
        end else begin
          exp_nxt = '0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      exp_bin <= '0;
      vld_p1  <= 1'b0;
      clr_p1  <= 1'b0;
    end else begin
      exp_bin <= exp_nxt;
      vld_p1  <= accept;
      clr_p1  <= brk;
    end
  end

  always_ff @(posedge clk) begin
    bin_p1 <= bus.s_tuser;
  end

  cplx_pow u_pow (
    .clk    (clk),
    .x      (cplx_t'(bus.s_tdata)),
    .pow_p1 (pow_p1)
  );

  // Stage 1: accumulate, a pending clear is applied before this beat
  always_comb begin
    cur_acc     = clr_p1 ? '0 : acc[bin_p1];
    cur_fcnt    = clr_p1 ? '0 : frame_cnt;
    sum_p1      = cur_acc + AW'(pow_p1);
    avg_p1      = avg_of(sum_p1);
    final_frame = (cur_fcnt == LAST_FRAME);
  end

  // Stage 2: registered results and error reporting
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < N_BINS; i++) acc[i] <= '0;
      frame_cnt    <= '0;
      bus.m_tdata  <= '0;
      bus.m_tuser  <= '0;
      bus.m_tvalid <= 1'b0;
      bus.m_tlast  <= 1'b0;
      bus.m_det    <= 1'b0;
      seq_err      <= 1'b0;
      err_cnt      <= '0;
    end else begin
      bus.m_tvalid <= 1'b0;
      bus.m_tlast  <= 1'b0;
      bus.m_det    <= 1'b0;
      seq_err      <= clr_p1;
      if (clr_p1) begin
        for (int i = 0; i < N_BINS; i++) acc[i] <= '0;
        frame_cnt <= '0;
        err_cnt   <= sat_inc(err_cnt);
      end
      if (vld_p1) begin
        if (final_frame) begin
          bus.m_tdata  <= avg_p1;
          bus.m_tuser  <= bin_p1;
          bus.m_tvalid <= 1'b1;
          bus.m_tlast  <= (bin_p1 == LAST_BIN);
          bus.m_det    <= (avg_p1 > thresh);
          acc[bin_p1]  <= '0;
          if (bin_p1 == LAST_BIN) frame_cnt <= '0;
        end else begin
          acc[bin_p1] <= sum_p1;
          if (bin_p1 == LAST_BIN) frame_cnt <= cur_fcnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_fft_bin_power_avg.sv
// Randomized and directed bench for fft_bin_power_avg against a per-bin averaging model.
module tb_fft_bin_power_avg;

  localparam int AVG = 16;

  logic        clk = 1'b0;
  logic        rstn = 1'b1;
  logic [31:0] thresh = 32'd0;
  logic        seq_err;
  logic [15:0] err_cnt;

  fft_bin_power_avg_if bus ();

  fft_bin_power_avg #(.LOG2_AVG(4)) dut (
    .clk     (clk),
    .rstn    (rstn),
    .bus     (bus),
    .thresh  (thresh),
    .seq_err (seq_err),
    .err_cnt (err_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    logic [31:0] data;
    logic [2:0]  user;
    bit          last;
    bit          det;
  } ev_t;

  ev_t    oq[$];
  int     eq[$];
  longint m_sum[8];
  int     m_frames, m_exp, m_err;
  int     cyc;
  int     checks, failures;
  int     n_out, det_cnt, tlast_cnt;
  logic [31:0] last_data;
  logic signed [15:0] fr_re[8];
  logic signed [15:0] fr_im[8];

  always @(posedge clk) cyc++;

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h cycle=%0d", name, act, req, cyc);
    end
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 8; i++) m_sum[i] = 0;
    m_frames = 0;
  endtask

  task automatic model_beat(input int re, input int im, input int u, input int c);
    bit     acc_b;
    longint p, avg;
    acc_b = 0;
    if (u == m_exp) begin
      acc_b = 1;
      m_exp = (m_exp + 1) % 8;
    end else begin
      eq.push_back(c + 2);
      model_clear();
      if (u == 0) begin
        acc_b = 1;
        m_exp = 1;
      end else m_exp = 0;
    end
    if (acc_b) begin
      p = longint'(re) * re + longint'(im) * im;
      m_sum[u] += p;
      if (m_frames == AVG - 1) begin
        avg = m_sum[u] / AVG;
        oq.push_back('{cyc: c + 2, data: 32'(avg), user: 3'(u), last: (u == 7),
                       det: (avg > longint'(thresh))});
        m_sum[u] = 0;
        if (u == 7) m_frames = 0;
      end else if (u == 7) m_frames++;
    end
  endtask

  task automatic drive(input logic signed [15:0] re, input logic signed [15:0] im, input logic [2:0] u);
    @(posedge clk); #1;
    bus.s_tvalid = 1'b1;
    bus.s_tdata  = {im, re};
    bus.s_tuser  = u;
    model_beat(int'(re), int'(im), int'(u), cyc);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      bus.s_tvalid = 1'b0;
    end
  endtask

  task automatic send_frame(input int gapmax);
    for (int b = 0; b < 8; b++) begin
      drive(fr_re[b], fr_im[b], 3'(b));
      if (gapmax > 0) idle($urandom_range(0, gapmax));
    end
  endtask

  task automatic set_const(input logic signed [15:0] re, input logic signed [15:0] im);
    for (int b = 0; b < 8; b++) begin
      fr_re[b] = re;
      fr_im[b] = im;
    end
  endtask

  task automatic set_rand();
    for (int b = 0; b < 8; b++) begin
      fr_re[b] = 16'($urandom);
      fr_im[b] = 16'($urandom);
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rstn = 1'b0;
    bus.s_tvalid = 1'b0;
    oq.delete();
    eq.delete();
    model_clear();
    m_exp = 0;
    m_err = 0;
    repeat (3) @(posedge clk);
    #1 rstn = 1'b1;
  endtask

  // Per-cycle comparison of every output against the model's schedule.
  always @(negedge clk) begin
    bit due_o, due_e;
    if (!rstn) begin
      chk("rst_m_tvalid", bus.m_tvalid, 0);
      chk("rst_m_tdata", bus.m_tdata, 0);
      chk("rst_m_tuser", bus.m_tuser, 0);
      chk("rst_m_tlast", bus.m_tlast, 0);
      chk("rst_m_det", bus.m_det, 0);
      chk("rst_seq_err", seq_err, 0);
      chk("rst_err_cnt", err_cnt, 0);
    end else begin
      due_o = (oq.size() > 0) && (oq[0].cyc == cyc);
      chk("m_tvalid", bus.m_tvalid, due_o);
      if (due_o) begin
        chk("m_tdata", bus.m_tdata, oq[0].data);
        chk("m_tuser", bus.m_tuser, oq[0].user);
        chk("m_tlast", bus.m_tlast, oq[0].last);
        chk("m_det", bus.m_det, oq[0].det);
        void'(oq.pop_front());
      end else begin
        chk("m_tlast_idle", bus.m_tlast, 0);
      end
      due_e = (eq.size() > 0) && (eq[0] == cyc);
      if (due_e) begin
        if (m_err < 65535) m_err++;
        void'(eq.pop_front());
      end
      chk("seq_err", seq_err, due_e);
      chk("err_cnt", err_cnt, 64'(m_err));
    end
    if (bus.m_tvalid) begin
      n_out++;
      last_data = bus.m_tdata;
      det_cnt   += int'(bus.m_det);
      tlast_cnt += int'(bus.m_tlast);
    end
  end

  initial begin
    int n0, d0, t0;
    bus.s_tvalid = 1'b0;
    bus.s_tdata  = '0;
    bus.s_tuser  = '0;
    model_clear();
    m_exp = 0;
    m_err = 0;
    #2 rstn = 1'b0;
    repeat (3) @(posedge clk);
    #1 rstn = 1'b1;

    // Constant 3+4j: power 25 everywhere, above threshold 24.
    thresh = 32'd24;
    set_const(16'sd3, 16'sd4);
    n0 = n_out; d0 = det_cnt; t0 = tlast_cnt;
    for (int f = 0; f < 16; f++) send_frame(0);
    idle(4);
    chk("const_n_out", 64'(n_out - n0), 8);
    chk("const_value", last_data, 25);
    chk("const_det_cnt", 64'(det_cnt - d0), 8);
    chk("const_tlast_cnt", 64'(tlast_cnt - t0), 1);

    // Full-scale negative input.
    thresh = 32'hFFFF_FFFF;
    set_const(-16'sd32768, -16'sd32768);
    n0 = n_out; d0 = det_cnt;
    for (int f = 0; f < 16; f++) send_frame(0);
    idle(4);
    chk("extreme_n_out", 64'(n_out - n0), 8);
    chk("extreme_value", last_data, 64'h8000_0000);
    chk("extreme_det_cnt", 64'(det_cnt - d0), 0);

    // Break 0,1,2,5 in the fourth frame: bin 5 is dropped.
    thresh = 32'h2000_0000;
    set_rand();
    for (int f = 0; f < 3; f++) send_frame(0);
    drive(fr_re[0], fr_im[0], 3'd0);
    drive(fr_re[1], fr_im[1], 3'd1);
    drive(fr_re[2], fr_im[2], 3'd2);
    drive(fr_re[5], fr_im[5], 3'd5);
    idle(4);
    chk("break_err_cnt", err_cnt, 1);
    n0 = n_out;
    for (int f = 0; f < 15; f++) begin set_rand(); send_frame(0); end
    idle(4);
    chk("break_no_early_out", 64'(n_out - n0), 0);
    set_rand(); send_frame(0);
    idle(4);
    chk("break_out_after_16", 64'(n_out - n0), 8);

    // Break by a stray bin 0 mid-frame: it starts the new frame.
    drive(fr_re[0], fr_im[0], 3'd0);
    drive(fr_re[1], fr_im[1], 3'd1);
    drive(fr_re[2], fr_im[2], 3'd2);
    for (int b = 0; b < 8; b++) drive(fr_re[b], fr_im[b], 3'(b));
    n0 = n_out;
    for (int f = 0; f < 15; f++) begin set_rand(); send_frame(0); end
    idle(4);
    chk("zero_break_err_cnt", err_cnt, 2);
    chk("zero_break_n_out", 64'(n_out - n0), 8);

    // Random data with idle gaps between beats.
    n0 = n_out;
    for (int f = 0; f < 16; f++) begin set_rand(); send_frame(3); end
    idle(4);
    chk("gaps_n_out", 64'(n_out - n0), 8);

    // Reset partway through a period.
    for (int f = 0; f < 8; f++) begin set_rand(); send_frame(1); end
    drive(fr_re[0], fr_im[0], 3'd0);
    drive(fr_re[1], fr_im[1], 3'd1);
    do_reset();
    n0 = n_out;
    for (int f = 0; f < 16; f++) begin set_rand(); send_frame(0); end
    idle(4);
    chk("post_reset_n_out", 64'(n_out - n0), 8);

    // Bin k averages to 16k: k frames of 16+0j, the rest zero, over two periods.
    thresh = 32'd50;
    n0 = n_out; t0 = tlast_cnt;
    for (int f = 0; f < 32; f++) begin
      for (int b = 0; b < 8; b++) begin
        fr_re[b] = ((f % 16) < b) ? 16'sd16 : 16'sd0;
        fr_im[b] = 16'sd0;
      end
      send_frame(0);
    end
    idle(4);
    chk("perbin_n_out", 64'(n_out - n0), 16);
    chk("perbin_last_value", last_data, 112);
    chk("perbin_tlast_cnt", 64'(tlast_cnt - t0), 2);
    chk("perbin_err_cnt", err_cnt, 0);

    chk("pending_outputs", 64'(oq.size()), 0);
    chk("pending_errors", 64'(eq.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
